// File: rtl/memory_access_stage.sv
// memory_access_stage: MEM stage of the RV32I pipeline.
// Drives a split-transaction data-memory port (req/gnt, then rvalid for loads),
// lane-aligns stores, extracts loads, stalls upstream while a transaction is
// outstanding and owns the MEM/WB pipeline register.
module memory_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  MemSizeM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,

    output logic        StallM,

    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic        ErrW
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } state_t;

    state_t        state;
    logic [CW-1:0] count;

    logic       is_load;
    logic       access;
    logic       misaligned;
    logic       aligned_access;
    logic [1:0] byte_off;

    logic [31:0] store_wdata;
    logic [3:0]  store_be;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    logic req_int;
    logic complete;
    logic err;
    logic capture;

    assign is_load  = (ResultSrcM == 2'b01);
    assign access   = MemWriteM | is_load;
    assign byte_off = ALU_ResultM[1:0];

    // Alignment check: halves need addr[0]=0, words need addr[1:0]=0.
    always_comb begin
        misaligned = 1'b0;
        case (MemSizeM[1:0])
            2'b01:   misaligned = byte_off[0];
            2'b10:   misaligned = |byte_off;
            default: misaligned = 1'b0;
        endcase
    end

    assign aligned_access = access & ~misaligned;

    // Store lane replication and byte enables.
    always_comb begin
        store_wdata = WriteDataM;
        store_be    = 4'b1111;
        case (MemSizeM[1:0])
            2'b00: begin
                store_wdata = {4{WriteDataM[7:0]}};
                store_be    = 4'b0001 << byte_off;
            end
            2'b01: begin
                store_wdata = {2{WriteDataM[15:0]}};
                store_be    = byte_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_wdata = WriteDataM;
                store_be    = 4'b1111;
            end
        endcase
    end

    // Load lane selection with sign or zero extension.
    always_comb begin
        lane_byte = dmem_rdata[{byte_off, 3'b000} +: 8];
        lane_half = byte_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (MemSizeM)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_data = {24'h000000, lane_byte};
            3'b101:  load_data = {16'h0000, lane_half};
            default: load_data = dmem_rdata;
        endcase
    end

    assign dmem_we    = MemWriteM;
    assign dmem_addr  = {ALU_ResultM[31:2], 2'b00};
    assign dmem_wdata = store_wdata;
    assign dmem_be    = MemWriteM ? store_be : 4'b0000;

    // Per-state request, completion and error decode for the current cycle.
    always_comb begin
        req_int  = 1'b0;
        complete = 1'b1;
        err      = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        err = 1'b1;
                    end else begin
                        req_int  = 1'b1;
                        complete = MemWriteM & dmem_gnt;
                    end
                end
            end
            WAIT_GNT: begin
                req_int  = 1'b1;
                complete = MemWriteM & dmem_gnt;
            end
            WAIT_RSP: begin
                if (dmem_rvalid) begin
                    capture = 1'b1;
                end else if (count == COUNT_LAST) begin
                    err = 1'b1;
                end else begin
                    complete = 1'b0;
                end
            end
            default: begin
                complete = 1'b1;
            end
        endcase
    end

    // The request is gated by reset so it drops immediately on assertion.
    assign dmem_req = req_int & reset;
    assign StallM   = access & ~complete;

    // Transaction FSM and response-wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (aligned_access && !(MemWriteM && dmem_gnt)) begin
                        state <= dmem_gnt ? WAIT_RSP : WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    count <= '0;
                    if (dmem_gnt) begin
                        state <= MemWriteM ? IDLE : WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (complete) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // MEM/WB register: load on completion, insert a bubble while stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= '0;
            RD_W        <= '0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            ErrW        <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
            ErrW      <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM & ~err;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= capture ? load_data : '0;
            ErrW        <= err;
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: scoreboard bench for memory_access_stage.
// Stimulus pushes expected memory requests and writeback results into queues;
// a memory responder and a writeback monitor pop and compare independently.
module tb_memory_access_stage;

    localparam int TO = 4;

    logic        clock;
    logic        reset;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  MemSizeM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
    logic        ErrW;

    memory_access_stage #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .MemSizeM(MemSizeM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .ErrW(ErrW)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rdv;
        bit          chk_rd;
        bit          err;
        int          stalls;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
        bit          is_load;
        int          g;
        int          k;
        logic [31:0] rdata;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   sb_on = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction, record its expected effects, hold it until not stalled.
    task automatic issue(input logic mw, input logic rw, input logic [1:0] rs,
                         input logic [2:0] sz, input logic [4:0] rd,
                         input logic [31:0] pc4, input logic [31:0] wd,
                         input logic [31:0] alu, input int g, input int k,
                         input logic [31:0] rdata);
        wb_t         w;
        req_t        r;
        int          nbytes, off, cyc;
        bit          ld, acc, mis, tmo;
        logic [31:0] mask, v;
        ld     = (rs == 2'b01);
        acc    = mw || ld;
        nbytes = (sz[1:0] == 2'b10) ? 4 : (sz[1:0] == 2'b01) ? 2 : 1;
        off    = int'(alu % 4);
        mis    = acc && ((off % nbytes) != 0);
        tmo    = ld && !mis && (k > TO);
        mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        v      = (rdata >> (8 * off)) & mask;
        if (!sz[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
        w.rw     = rw && !(mis || tmo);
        w.rs     = rs;
        w.rd     = rd;
        w.pc4    = pc4;
        w.alu    = alu;
        w.rdv    = v;
        w.chk_rd = ld && !mis && !tmo;
        w.err    = mis || tmo;
        if (!acc || mis) w.stalls = 0;
        else if (mw)     w.stalls = g;
        else if (tmo)    w.stalls = g + TO;
        else             w.stalls = g + k;
        @(posedge clock); #1;
        MemWriteM = mw; RegWriteM = rw; ResultSrcM = rs; MemSizeM = sz;
        RD_M = rd; PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = alu;
        if (acc && !mis) begin
            r.addr    = alu & 32'hFFFF_FFFC;
            r.we      = mw;
            r.be      = mw ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
            r.wdata   = (nbytes == 1) ? wd[7:0] * 32'h0101_0101 :
                        (nbytes == 2) ? wd[15:0] * 32'h0001_0001 : wd;
            r.is_load = ld;
            r.g       = g;
            r.k       = k;
            r.rdata   = rdata;
            req_q.push_back(r);
        end
        wb_q.push_back(w);
        sb_on = 1;
        cyc = 0;
        forever begin
            #3;
            if (!StallM) break;
            cyc++;
            if (cyc > 100) begin
                $display("FAIL stall_bound actual=%0d required<=100", cyc);
                bad++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "stall bound exceeded");
            end
            @(posedge clock); #1;
        end
    endtask

    // Memory responder: grants after the planned delay, checks request fields, returns load data.
    initial begin
        bit   busy, in_rsp, late;
        int   cnt;
        req_t cur;
        busy = 0; in_rsp = 0; late = 0; cnt = 0;
        forever begin
            @(posedge clock); #3;
            if (!sb_on) continue;
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (late) begin
                dmem_rvalid = 1'b1; dmem_rdata = $urandom; late = 0;
            end else if (!in_rsp && $urandom_range(0, 3) == 0) begin
                dmem_rvalid = 1'b1; dmem_rdata = $urandom;
            end
            if (in_rsp) begin
                cnt++;
                if (cnt == cur.k) begin
                    dmem_rvalid = 1'b1; dmem_rdata = cur.rdata;
                    in_rsp = 0; busy = 0;
                end else if (cur.k > TO && cnt == TO) begin
                    in_rsp = 0; busy = 0; late = 1;
                end
            end else if (dmem_req) begin
                if (!busy) begin
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req actual=req addr=%h required=no request", dmem_addr);
                    end else begin
                        cur = req_q.pop_front(); busy = 1; cnt = 0;
                    end
                end
                if (busy) begin
                    if (cnt < cur.g) cnt++;
                    else begin
                        dmem_gnt = 1'b1;
                        check("req_addr", dmem_addr, cur.addr);
                        check("req_we", 32'(dmem_we), 32'(cur.we));
                        check("req_be", 32'(dmem_be), 32'(cur.be));
                        if (!cur.is_load) check("req_wdata", dmem_wdata, cur.wdata);
                        if (cur.is_load) begin in_rsp = 1; cnt = 0; end
                        else busy = 0;
                    end
                end
            end
        end
    end

    // Writeback monitor: compares MEM/WB on each completion, checks bubbles on stalls.
    initial begin
        bit  have_prev, prev_stall;
        int  run;
        wb_t e;
        have_prev = 0; prev_stall = 0; run = 0;
        forever begin
            @(posedge clock); #1;
            if (sb_on && have_prev) begin
                if (prev_stall) begin
                    run++;
                    check("bubble_regwrite", 32'(RegWriteW), 32'd0);
                    check("bubble_err", 32'(ErrW), 32'd0);
                end else if (wb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_wb actual=completion required=none");
                end else begin
                    e = wb_q.pop_front();
                    check("wb_regwrite", 32'(RegWriteW), 32'(e.rw));
                    check("wb_resultsrc", 32'(ResultSrcW), 32'(e.rs));
                    check("wb_rd", 32'(RD_W), 32'(e.rd));
                    check("wb_pc4", PCPlus4W, e.pc4);
                    check("wb_alu", ALU_ResultW, e.alu);
                    check("wb_err", 32'(ErrW), 32'(e.err));
                    if (e.chk_rd) check("wb_readdata", ReadDataW, e.rdv);
                    check("stall_cycles", 32'(run), 32'(e.stalls));
                    run = 0;
                end
            end
            #3;
            have_prev  = sb_on;
            prev_stall = StallM;
        end
    end

    initial begin
        reset = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        // An aligned store is presented during reset: no request may appear.
        MemWriteM = 1'b1; RegWriteM = 1'b0; ResultSrcM = 2'b00; MemSizeM = 3'b010;
        RD_M = 5'd0; PCPlus4M = 32'h0; WriteDataM = 32'hDEAD_BEEF; ALU_ResultM = 32'h100;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_regwrite", 32'(RegWriteW), 32'd0);
        check("rst_err", 32'(ErrW), 32'd0);
        check("rst_alu", ALU_ResultW, 32'd0);
        check("rst_readdata", ReadDataW, 32'd0);
        check("rst_pc4", PCPlus4W, 32'd0);
        check("rst_rd", 32'(RD_W), 32'd0);
        check("rst_resultsrc", 32'(ResultSrcW), 32'd0);

        MemWriteM = 1'b0; RegWriteM = 1'b1; ALU_ResultM = 32'hCAFE_0001; RD_M = 5'd3; PCPlus4M = 32'h10;
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        check("alu_pre_alu", ALU_ResultW, 32'hCAFE_0001);
        check("alu_pre_rd", 32'(RD_W), 32'd3);
        check("alu_pre_regwrite", 32'(RegWriteW), 32'd1);

        // Load granted immediately, then reset while waiting for the response.
        ResultSrcM = 2'b01; MemSizeM = 3'b010; ALU_ResultM = 32'h200; RD_M = 5'd5;
        dmem_gnt = 1'b1;
        #3;
        check("ld_req", 32'(dmem_req), 32'd1);
        check("ld_gnt_stall", 32'(StallM), 32'd1);
        @(posedge clock); #1;
        dmem_gnt = 1'b0;
        #3;
        check("wait_rsp_req", 32'(dmem_req), 32'd0);
        check("wait_rsp_stall", 32'(StallM), 32'd1);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        check("midrst_req", 32'(dmem_req), 32'd0);
        check("midrst_regwrite", 32'(RegWriteW), 32'd0);
        check("midrst_alu", ALU_ResultW, 32'd0);
        check("midrst_rd", 32'(RD_W), 32'd0);
        check("midrst_pc4", PCPlus4W, 32'd0);
        check("midrst_err", 32'(ErrW), 32'd0);
        ResultSrcM = 2'b00; RegWriteM = 1'b1; ALU_ResultM = 32'h1234_5678; RD_M = 5'd7; PCPlus4M = 32'h44;
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #3;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA_55AA;
        #1;
        check("post_rst_stall", 32'(StallM), 32'd0);
        check("post_rst_req", 32'(dmem_req), 32'd0);
        @(posedge clock); #1;
        dmem_rvalid = 1'b0;
        check("post_rst_alu", ALU_ResultW, 32'h1234_5678);
        check("post_rst_rd", 32'(RD_W), 32'd7);
        check("post_rst_regwrite", 32'(RegWriteW), 32'd1);
        check("post_rst_err", 32'(ErrW), 32'd0);

        // Directed scoreboard items.
        issue(1'b1, 1'b0, 2'b00, 3'b010, 5'd0, 32'h104, 32'hDEAD_BEEF, 32'h100, 0, 0, 32'h0);
        issue(1'b1, 1'b0, 2'b00, 3'b000, 5'd0, 32'h108, 32'h0000_00A5, 32'h103, 1, 0, 32'h0);
        issue(1'b0, 1'b1, 2'b01, 3'b000, 5'd9, 32'h10C, 32'h0, 32'h102, 0, 2, 32'h12F0_5678);
        issue(1'b0, 1'b1, 2'b01, 3'b100, 5'd10, 32'h110, 32'h0, 32'h102, 0, 2, 32'h12F0_5678);
        issue(1'b0, 1'b1, 2'b01, 3'b001, 5'd11, 32'h114, 32'h0, 32'h101, 0, 1, 32'h0);
        issue(1'b0, 1'b1, 2'b01, 3'b010, 5'd12, 32'h118, 32'h0, 32'h300, 3, 99, 32'h0);
        issue(1'b0, 1'b1, 2'b00, 3'b000, 5'd13, 32'h11C, 32'h0, 32'hABCD_0000, 0, 0, 32'h0);

        // Randomized mix.
        for (int i = 0; i < 200; i++) begin
            int          kind, nb;
            logic [2:0]  sz;
            logic [1:0]  rs;
            logic        mw;
            logic [31:0] alu;
            logic [2:0]  ld_sizes [5];
            ld_sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            kind = $urandom_range(0, 3);
            alu  = $urandom;
            case (kind)
                0: begin mw = 1'b0; rs = 2'b00; sz = 3'($urandom_range(0, 7)); end
                1: begin mw = 1'b0; rs = 2'b10; sz = 3'($urandom_range(0, 7)); end
                2: begin mw = 1'b0; rs = 2'b01; sz = ld_sizes[$urandom_range(0, 4)]; end
                default: begin
                    mw = 1'b1; rs = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
                    sz = 3'($urandom_range(0, 2));
                end
            endcase
            nb = (sz[1:0] == 2'b10) ? 4 : (sz[1:0] == 2'b01) ? 2 : 1;
            if ($urandom_range(0, 2) != 0) alu = alu & ~32'(nb - 1);
            issue(mw, 1'($urandom_range(0, 1)), rs, sz, 5'($urandom), $urandom, $urandom,
                  alu, $urandom_range(0, 3), $urandom_range(1, TO + 2), $urandom);
        end

        @(posedge clock); #2;
        sb_on = 0;
        check("wb_queue_drained", 32'(wb_q.size()), 32'd0);
        check("req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
